// File: rtl/miner_pkg.sv
// Shared SHA-256 definitions for the SHA-256d header hasher: round constants,
// initial hash value, FSM states and the 32-bit mixing functions.
package miner_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD1,
        RND1,
        LOAD2,
        RND2,
        LOAD3,
        RND3,
        DONE
    } state_t;

    // Working variables a..h; a lands in the most significant word.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } work_t;

    localparam work_t IV = '{
        a: 32'h6a09e667, b: 32'hbb67ae85, c: 32'h3c6ef372, d: 32'ha54ff53a,
        e: 32'h510e527f, f: 32'h9b05688c, g: 32'h1f83d9ab, h: 32'h5be0cd19
    };

    localparam logic [63:0] HEADER_BITS = 64'd640;
    localparam logic [63:0] DIGEST_BITS = 64'd256;
    localparam logic [5:0]  LAST_ROUND  = 6'd63;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, y, z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, y, z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Lane-wise mod 2^32 sum used to fold a block result into the chaining value.
    function automatic work_t add_work(input work_t x, input work_t y);
        work_t s;
        s.a = x.a + y.a;
        s.b = x.b + y.b;
        s.c = x.c + y.c;
        s.d = x.d + y.d;
        s.e = x.e + y.e;
        s.f = x.f + y.f;
        s.g = x.g + y.g;
        s.h = x.h + y.h;
        return s;
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One SHA-256 compression round: current a..h plus W[t] and K[t] give the next a..h.
module sha256_round
    import miner_pkg::*;
(
    input  work_t       cur,
    input  logic [31:0] w,
    input  logic [31:0] k,
    output work_t       nxt
);

    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        t1 = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
        t2 = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);

        nxt.a = t1 + t2;
        nxt.b = cur.a;
        nxt.c = cur.b;
        nxt.d = cur.c;
        nxt.e = cur.d + t1;
        nxt.f = cur.e;
        nxt.g = cur.f;
        nxt.h = cur.g;
    end

endmodule

// File: rtl/miner.sv
// SHA-256d of an 80-byte block header using one iterative compression core
// shared across the three compressions (two header blocks, then the digest block).
module miner
    import miner_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [639:0] header,
    output logic [255:0] outputHash
);

    state_t       state;
    logic [639:0] hdr_q;
    logic [5:0]   rnd;
    work_t        work;
    work_t        work_next;
    work_t        chain;
    work_t        block_sum;
    logic [31:0]  win [0:15];
    logic [31:0]  w_new;
    logic [511:0] load_block;

    sha256_round u_round (
        .cur (work),
        .w   (win[0]),
        .k   (K[rnd]),
        .nxt (work_next)
    );

    // Message schedule: win[0] is W[t]; the word 16 places ahead is built from the window.
    assign w_new = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];

    assign block_sum = add_work(chain, work_next);

    // Padding mux. The third block reads chain before LOAD3 resets it to the IV.
    always_comb begin
        load_block = '0;
        case (state)
            LOAD1:   load_block = hdr_q[639:128];
            LOAD2:   load_block = {hdr_q[127:0], 8'h80, 312'd0, HEADER_BITS};
            LOAD3:   load_block = {chain, 8'h80, 184'd0, DIGEST_BITS};
            default: load_block = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            hdr_q      <= '0;
            rnd        <= '0;
            work       <= '0;
            chain      <= '0;
            outputHash <= '0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    hdr_q <= header;
                    state <= LOAD1;
                end

                LOAD1, LOAD2, LOAD3: begin
                    for (int i = 0; i < 16; i++) begin
                        win[i] <= load_block[511 - 32*i -: 32];
                    end
                    rnd <= '0;
                    if (state == LOAD2) begin
                        work <= chain;
                    end else begin
                        work  <= IV;
                        chain <= IV;
                    end
                    case (state)
                        LOAD1:   state <= RND1;
                        LOAD2:   state <= RND2;
                        default: state <= RND3;
                    endcase
                end

                RND1, RND2, RND3: begin
                    work <= work_next;
                    rnd  <= rnd + 6'd1;
                    for (int i = 0; i < 15; i++) begin
                        win[i] <= win[i + 1];
                    end
                    win[15] <= w_new;
                    if (rnd == LAST_ROUND) begin
                        chain <= block_sum;
                        case (state)
                            RND1:    state <= LOAD2;
                            RND2:    state <= LOAD3;
                            default: begin
                                outputHash <= block_sum;
                                state      <= DONE;
                            end
                        endcase
                    end
                end

                DONE: state <= DONE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_miner.sv
// Directed bench for the SHA-256d header hasher: reset hold, genesis-block golden,
// hold after completion, abort/restart with header disturbance, zero and random headers.
module tb_miner;

    logic         clk;
    logic         rst;
    logic [639:0] header;
    logic [255:0] outputHash;

    int n_cmp;
    int n_err;

    localparam logic [639:0] GENESIS_HDR = 640'h01000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_3ba3edfd_7a7b12b2_7ac72c3e_67768f61_7fc81bc3_888a5132_3a9fb8aa_4b1e5e4a_29ab5f49_ffff001d_1dac2b7c;
    localparam logic [255:0] GENESIS_HASH = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
    localparam logic [255:0] ABC_HASH     = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_HASH   = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] SHA_IV       = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam int           LATENCY      = 195;

    miner dut (
        .clk        (clk),
        .rst        (rst),
        .header     (header),
        .outputHash (outputHash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: straightforward SHA-256 with a fully expanded schedule.
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] hout;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + miner_pkg::K[t] + w[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) hout[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return hout;
    endfunction

    function automatic logic [255:0] ref_sha256d(input logic [639:0] hdr);
        logic [255:0] h1;
        h1 = ref_compress(SHA_IV, hdr[639:128]);
        h1 = ref_compress(h1, {hdr[127:0], 1'b1, 319'd0, 64'd640});
        return ref_compress(SHA_IV, {h1, 1'b1, 191'd0, 64'd256});
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %064h expected %064h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
    endtask

    // Releases reset, then checks the output is 0 until exactly LATENCY edges after capture.
    task automatic run_hash(input string tag, input logic [639:0] hdr,
                            input logic [255:0] exp, input bit disturb);
        @(negedge clk);
        rst    = 1'b1;
        header = hdr;
        @(posedge clk);
        for (int k = 1; k <= LATENCY; k++) begin
            @(posedge clk);
            #1;
            if (disturb && k == 1) header = ~hdr;
            if (k < LATENCY) check({tag, "_busy"}, outputHash, '0);
            else             check({tag, "_digest"}, outputHash, exp);
        end
    endtask

    initial begin
        logic [639:0] rnd_hdr;
        logic [255:0] zero_exp;
        n_cmp  = 0;
        n_err  = 0;
        rst    = 1'b0;
        header = '0;

        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", outputHash, '0);
        end

        check("model_abc", ref_compress(SHA_IV, {24'h616263, 1'b1, 423'd0, 64'd24}), ABC_HASH);
        check("model_empty", ref_compress(SHA_IV, {1'b1, 447'd0, 64'd0}), EMPTY_HASH);
        check("model_genesis", ref_sha256d(GENESIS_HDR), GENESIS_HASH);

        run_hash("genesis", GENESIS_HDR, GENESIS_HASH, 1'b0);

        for (int k = 1; k <= 500; k++) begin
            @(posedge clk);
            #1;
            if (k % 100 == 0) check("done_hold", outputHash, GENESIS_HASH);
        end

        do_reset();
        #1;
        check("reset_after_done", outputHash, '0);
        @(negedge clk);
        rst    = 1'b1;
        header = GENESIS_HDR;
        @(posedge clk);
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            check("pre_abort_busy", outputHash, '0);
        end
        do_reset();
        #1;
        check("abort", outputHash, '0);
        run_hash("restart_disturbed", GENESIS_HDR, GENESIS_HASH, 1'b1);

        do_reset();
        zero_exp = ref_sha256d('0);
        run_hash("zero_header", '0, zero_exp, 1'b0);

        for (int i = 0; i < 20; i++) rnd_hdr[32*i +: 32] = $urandom;
        do_reset();
        run_hash("random_header", rnd_hdr, ref_sha256d(rnd_hdr), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
